scan_rr_arbiter: RTL
====================

# scan_rr_arbiter

Round-robin arbiter that shares one downstream resource (display/scan datapath slot) among four requesters. It uses a 2-bit wrapping priority pointer as its scheduling core. The arbiter grants one requester at a time, holds the grant while that request stays asserted, and forces release after a programmable hold limit. A one-cycle turnaround separates consecutive grants.

## Interface
- MAX_HOLD, 16, maximum consecutive cycles a grant may be held; 0 disables timeout
- CNT_W, 5, hold counter width; must satisfy 2^CNT_W > MAX_HOLD
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- req  input  4  request lines, level-sensitive, bit i = requester i
- grant  output  4  one-hot grant, registered; 0000 when no grant
- grant_id  output  2  index of current or last granted requester, registered
- busy  output  1  high while in GRANT state
- timeout_pulse  output  1  one-cycle pulse when a grant is forcibly revoked

## Operation
- Reset values: grant=0000, grant_id=0, busy=0, timeout_pulse=0, ptr=0, hold_cnt=0, state=IDLE.
- ptr[1:0] is the priority pointer. It marks the first index searched and wraps 3->0.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If req==0000, stay in IDLE.
  - Otherwise the winner is the first set bit of req, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - On the next edge: grant<=onehot(winner), grant_id<=winner, ptr<=winner+1 mod 4, hold_cnt<=0, state<=GRANT.
- GRANT:
  - hold_cnt increments each cycle.
  - If req[grant_id]==0: grant<=0000, state<=RELEASE (normal release).
  - Else if MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1: grant<=0000, timeout_pulse<=1, state<=RELEASE (forced).
  - Otherwise hold the grant.
  - Other req bits are ignored while in GRANT.
- RELEASE: grant=0000 for exactly one cycle, then state<=IDLE. All req bits are ignored in RELEASE.
- grant_id retains its value after release. It is meaningful only when busy=1.
- At most one grant bit is ever set. grant is nonzero iff busy=1.

## Timing
- Request to grant: req sampled high in IDLE at edge N gives grant high after edge N.
- Hold limit: with a continuously held request, grant stays high for exactly MAX_HOLD cycles.
- Normal release: req[grant_id] sampled low at edge E gives grant low after edge E. The earliest next grant is after edge E+2, so grant is low for exactly 2 cycles between back-to-back grants.
- timeout_pulse is high for exactly the one cycle following revocation; it coincides with the first cycle of RELEASE.
- Drop and limit in the same cycle: if req drops in the same cycle hold_cnt==MAX_HOLD-1, it is a normal release and timeout_pulse stays 0.
- A timed-out requester that still requests competes normally. ptr has already moved past it, so it is re-granted only if no higher-priority requester is pending.
- Reset asserted mid-GRANT clears all outputs asynchronously, without waiting for a clock edge. After deassertion the arbiter starts from IDLE with ptr=0.
- busy and grant are registered; no combinational path from req to any output.

## Test plan
- Reset then single request: assert reset, check all outputs 0. Release reset, set req=0001, check grant=0001, grant_id=0, busy=1 one edge later. Drop req and check grant=0000 after the next edge, with 2 idle cycles.
- Full contention: req=1111, each owner drops its bit 3 cycles after grant and reasserts 1 cycle later. Required grant order is 0,1,2,3,0, with exactly 2 zero-grant cycles between grants.
- Timeout with MAX_HOLD=4: req=0010 held high. Grant 0010 for exactly 4 cycles, timeout_pulse high 1 cycle, 2 cycles of grant=0000, then 0010 re-granted.
- Pointer wrap: grant requester 2 and release, then apply req=1001. Required order is 3 then 0.
- Drop on the limit cycle with MAX_HOLD=4: drop req on the 4th grant cycle. Required: timeout_pulse stays 0 and it is treated as a normal release.
- Reset mid-grant: pulse reset during a grant to 0100. grant=0000 and busy=0 before the next clock edge. Then req=1111 yields grant 0001 first (ptr=0).

Source files
------------

// File: rtl/scan_rr_arbiter.sv
// -----------------------------------------------------------------------------
// scan_rr_arbiter
//
// Round-robin arbiter sharing one downstream display/scan datapath slot among
// four requesters. A 2-bit wrapping priority pointer decides which requester
// is searched first. A grant is held while its request stays asserted. It is
// forcibly revoked after MAX_HOLD cycles, unless MAX_HOLD is 0. A one-cycle
// RELEASE turnaround separates consecutive grants.
//
// Parameters
//   MAX_HOLD  maximum consecutive grant cycles; 0 disables the timeout
//   CNT_W     hold counter width; 2**CNT_W must exceed MAX_HOLD
//
// Ports
//   clk            in   1  clock, rising edge
//   reset          in   1  asynchronous, active-high; clears all state at once
//   req            in   4  level-sensitive request lines, bit i = requester i
//   grant          out  4  registered one-hot grant; 0000 when nothing granted
//   grant_id       out  2  registered index of the current or last grantee
//   busy           out  1  high while the FSM is in GRANT
//   timeout_pulse  out  1  one-cycle pulse in the first RELEASE cycle after
//                          a forced revocation
//   fsm_state      out  2  debug view of the FSM state
//                          (0 = IDLE, 1 = GRANT, 2 = RELEASE)
//
// There is no valid/ready handshake. req is a plain level request, and grant
// is a level acknowledgement that lasts while the request is held and the
// hold limit has not been reached.
// -----------------------------------------------------------------------------
module scan_rr_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic       timeout_pulse,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Counter value seen during the last permitted grant cycle. It is only
    // used when the timeout is enabled.
    localparam logic [CNT_W-1:0] HOLD_LAST =
        CNT_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam bit TIMEOUT_EN = (MAX_HOLD != 0);

    state_t           state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] hold_cnt;

    // Combinational winner search, used only in IDLE.
    logic [1:0]       winner;
    logic             win_valid;
    logic [1:0]       idx;

    logic             owner_req;
    logic             hold_limit;

    assign fsm_state = state;

    // Search ptr, ptr+1, ptr+2, ptr+3 (mod 4). The loop runs from the
    // farthest offset to the nearest, so the nearest set bit is written last
    // and wins.
    always_comb begin
        winner    = ptr;
        win_valid = 1'b0;
        idx       = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                winner    = idx;
                win_valid = 1'b1;
            end
        end
    end

    assign owner_req  = req[grant_id];
    assign hold_limit = TIMEOUT_EN && (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            ptr           <= 2'd0;
            hold_cnt      <= '0;
            grant         <= 4'b0000;
            grant_id      <= 2'd0;
            busy          <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            // timeout_pulse is high only in the single cycle after a
            // revocation, so it defaults low every cycle.
            timeout_pulse <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        grant    <= 4'b0001 << winner;
                        grant_id <= winner;
                        ptr      <= winner + 2'd1;
                        hold_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= ST_GRANT;
                    end
                end

                ST_GRANT: begin
                    hold_cnt <= hold_cnt + CNT_W'(1);
                    // A dropped request takes precedence over the hold limit.
                    // A drop on the limit cycle is a normal release.
                    if (!owner_req) begin
                        grant <= 4'b0000;
                        busy  <= 1'b0;
                        state <= ST_RELEASE;
                    end else if (hold_limit) begin
                        grant         <= 4'b0000;
                        busy          <= 1'b0;
                        timeout_pulse <= 1'b1;
                        state         <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    // Turnaround cycle. All requests are ignored here.
                    state <= ST_IDLE;
                end

                default: begin
                    grant <= 4'b0000;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
